register_file: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the single-cycle MIPS datapath.
- Two asynchronous (combinational) read ports and one synchronous write port.
- Register 0 is hard-wired to zero.
- Sits between instruction decode and the ALU:
  - Read addresses come from the rs/rt fields.
  - Write address and data come from the writeback mux.

---
 rtl/register_file.sv | 70 +++++++
 tb/tb_register_file.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// 32 x 32 MIPS general-purpose register file: two combinational read ports,
// one synchronous write port, register 0 hard-wired to zero.

module register_file_entry #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] d_i,
    output logic [DATA_WIDTH-1:0] q_o
);
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (we_i) data_d = d_i;
    end

    // Async clear wins over any write presented while reset_n is low.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) data_q <= '0;
        else          data_q <= data_d;
    end

    assign q_o = data_q;
endmodule

module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] ReadReg1,
    input  logic [ADDR_WIDTH-1:0] ReadReg2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
    logic [DEPTH-1:0]                 we;

    // Entry 0 has no storage; its decode line is left unused-free by tying it low.
    assign regs[0] = '0;
    assign we[0]   = 1'b0;

    for (genvar i = 1; i < DEPTH; i++) begin : g_entry
        assign we[i] = RegWrite && (WriteReg == ADDR_WIDTH'(i));

        register_file_entry #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_entry (
            .clock  (clock),
            .reset_n(reset_n),
            .we_i   (we[i]),
            .d_i    (WriteData),
            .q_o    (regs[i])
        );
    end

    // No write bypass: reads see the stored value, old before the edge, new after.
    assign ReadData1 = regs[ReadReg1];
    assign ReadData2 = regs[ReadReg2];
endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: expected read data comes from a bench-side
// register model and is queued at stimulus time, then popped when sampled.

module tb_register_file;
    logic        clock;
    logic        reset_n;
    logic [4:0]  ReadReg1, ReadReg2, WriteReg;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic [31:0] ReadData1, ReadData2;

    typedef struct {
        string       tag;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [32];
    int          checks = 0;
    int          errors = 0;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ReadReg1 (ReadReg1),
        .ReadReg2 (ReadReg2),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .RegWrite (RegWrite),
        .ReadData1(ReadData1),
        .ReadData2(ReadData2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mrd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : model[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    // Set read addresses, queue the model's answer, then sample after settling.
    task automatic chk(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        ReadReg1 = a1;
        ReadReg2 = a2;
        sb.push_back('{tag, mrd(a1), mrd(a2)});
        #1;
        e = sb.pop_front();
        checks++;
        assert (ReadData1 === e.e1) else begin
            errors++;
            $error("FAIL %s rd1 (addr %0d): got %h expected %h", e.tag, a1, ReadData1, e.e1);
        end
        checks++;
        assert (ReadData2 === e.e2) else begin
            errors++;
            $error("FAIL %s rd2 (addr %0d): got %h expected %h", e.tag, a2, ReadData2, e.e2);
        end
    endtask

    // Present a write, clock it, and apply the same write to the model.
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic we);
        WriteReg  = a;
        WriteData = d;
        RegWrite  = we;
        @(posedge clock);
        #1;
        if (reset_n && we && a != 5'd0) model[a] = d;
    endtask

    initial begin
        model_clear();
        reset_n   = 1'b0;
        ReadReg1  = '0;
        ReadReg2  = '0;
        WriteReg  = '0;
        WriteData = '0;
        RegWrite  = 1'b0;

        // 1: reset then read
        repeat (2) @(posedge clock);
        #1;
        chk("in_reset", 5'd1, 5'd2);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_r0_r1", 5'd0, 5'd1);
        chk("rst_r2_r3", 5'd2, 5'd3);

        // 2: write to $zero ignored
        ReadReg1 = 5'd2;
        ReadReg2 = 5'd3;
        wr(5'd0, 32'd10, 1'b1);
        chk("zero_wr_r2_r3", 5'd2, 5'd3);
        chk("zero_wr_r0", 5'd0, 5'd0);

        // 3: same-cycle read of destination, old value before edge
        WriteReg  = 5'd1;
        WriteData = 32'd11;
        RegWrite  = 1'b1;
        chk("pre_edge", 5'd0, 5'd1);
        wr(5'd1, 32'd11, 1'b1);
        RegWrite = 1'b0;
        chk("post_edge", 5'd0, 5'd1);

        // 4: write enable low
        repeat (3) wr(5'd5, 32'hDEADBEEF, 1'b0);
        chk("we_low", 5'd5, 5'd5);
        wr(5'd5, 32'hDEADBEEF, 1'b1);
        RegWrite = 1'b0;
        chk("we_high", 5'd5, 5'd1);

        // 5: full sweep, paired reads
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101, 1'b1);
        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) chk("sweep", 5'(i), 5'(31 - i));
        chk("same_addr", 5'd17, 5'd17);

        // 6: async reset between edges, then write during reset is dropped
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        model_clear();
        chk("async_rst", 5'd1, 5'd31);
        wr(5'd7, 32'h12345678, 1'b1);
        reset_n  = 1'b1;
        RegWrite = 1'b0;
        @(posedge clock);
        #1;
        chk("wr_in_rst", 5'd7, 5'd1);
        wr(5'd7, 32'hCAFEF00D, 1'b1);
        RegWrite = 1'b0;
        chk("post_rst_wr", 5'd7, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
